// File: rtl/dm_core.sv
// dm_core: debug module core with a DMI register file, an abstract command FSM and a hart-side bus.
// Define DM_TIMEOUT_EN to add a command watchdog that ends a command with cmderr=3 after TIMEOUT cycles.
module dm_core #(
  parameter int DATA_COUNT   = 2,
  parameter int PROGBUF_SIZE = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dmi_valid,
  input  logic        dmi_wr,
  input  logic [6:0]  dmi_addr,
  input  logic [31:0] dmi_wdata,
  output logic [31:0] dmi_rdata,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic        bus_write,
  input  logic [17:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        hart_halted,
  output logic        haltreq
);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {ST_IDLE, ST_GO, ST_EXEC} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cmderr, w_cmderr_nxt;
  logic        r_haltreq, r_dmactive, r_bus_ready;
  logic [31:0] r_dmi_rdata, r_bus_rdata;
  logic [31:0] r_data    [DATA_COUNT];
  logic [31:0] r_progbuf [PROGBUF_SIZE];
  logic        w_busy, w_dmi_we, w_dmi_re, w_bus_fire, w_bus_we, w_bus_re, w_dmi_buf_hit;
  logic [31:0] w_dmi_rval, w_bus_rval, w_abstractcs;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_dmi_we   = dmi_valid & dmi_wr;
  assign w_dmi_re   = dmi_valid & ~dmi_wr;
  assign w_bus_fire = bus_valid & r_bus_ready;
  assign w_bus_we   = w_bus_fire & bus_write;
  assign w_bus_re   = w_bus_fire & ~bus_write;

  assign w_abstractcs = {3'b0, 5'(PROGBUF_SIZE), 11'b0, w_busy, 1'b0, r_cmderr, 4'b0, 4'(DATA_COUNT)};

  assign dmi_rdata = r_dmi_rdata;
  assign bus_rdata = r_bus_rdata;
  assign bus_ready = r_bus_ready;
  assign haltreq   = r_haltreq & r_dmactive;

  always_comb begin
    w_dmi_rval    = '0;
    w_dmi_buf_hit = 1'b0;
    case (dmi_addr)
      7'h10:   w_dmi_rval = {r_haltreq, 30'b0, r_dmactive};
      7'h11:   w_dmi_rval = {22'b0, hart_halted, hart_halted, 4'b0, 4'd2};
      7'h16:   w_dmi_rval = w_abstractcs;
      default: ;
    endcase
    for (int unsigned i = 0; i < DATA_COUNT; i++) begin
      if (dmi_addr == 7'(32'h04 + i)) begin
        w_dmi_rval    = r_data[i];
        w_dmi_buf_hit = 1'b1;
      end
    end
    for (int unsigned i = 0; i < PROGBUF_SIZE; i++) begin
      if (dmi_addr == 7'(32'h20 + i)) begin
        w_dmi_rval    = r_progbuf[i];
        w_dmi_buf_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_bus_rval = '0;
    if (bus_addr == 18'(PROGBUF_SIZE)) w_bus_rval = EBREAK;
    if (bus_addr == 18'h200)           w_bus_rval = {31'b0, r_state == ST_GO};
    for (int unsigned i = 0; i < PROGBUF_SIZE; i++)
      if (bus_addr == 18'(i)) w_bus_rval = r_progbuf[i];
    for (int unsigned i = 0; i < DATA_COUNT; i++)
      if (bus_addr == 18'(32'h100 + i)) w_bus_rval = r_data[i];
  end

`ifdef DM_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] r_tmo;

  // Counter is held at zero whenever idle, so it restarts on every entry to GO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           r_tmo <= '0;
    else if (!r_dmactive || !w_busy)       r_tmo <= '0;
    else                                   r_tmo <= r_tmo + 32'd1;
  end
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // DMI effects on cmderr are applied first; hart completion and timeout override them.
  always_comb begin
    w_state_nxt  = r_state;
    w_cmderr_nxt = r_cmderr;
    if (w_dmi_we) begin
      if (dmi_addr == 7'h16) begin
        w_cmderr_nxt = r_cmderr & ~dmi_wdata[10:8];
      end else if (dmi_addr == 7'h17) begin
        if (w_busy)                 w_cmderr_nxt = 3'd1;
        else if (r_cmderr == 3'd0) begin
          if (!hart_halted)         w_cmderr_nxt = 3'd4;
          else                      w_state_nxt  = ST_GO;
        end
      end else if (w_dmi_buf_hit && w_busy) begin
        w_cmderr_nxt = 3'd1;
      end
    end
    case (r_state)
      ST_GO:   if (w_bus_re && bus_addr == 18'h200) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_bus_we && bus_addr == 18'h201) w_state_nxt = ST_IDLE;
        if (w_bus_we && bus_addr == 18'h202) begin
          w_state_nxt  = ST_IDLE;
          w_cmderr_nxt = 3'd3;
        end
      end
      default: ;
    endcase
`ifdef DM_TIMEOUT_EN
    if (w_busy && r_tmo == TMO_LAST) begin
      w_state_nxt  = ST_IDLE;
      w_cmderr_nxt = 3'd3;
    end
`endif
    if (!r_dmactive) begin
      w_state_nxt  = ST_IDLE;
      w_cmderr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cmderr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cmderr <= w_cmderr_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_haltreq   <= 1'b0;
      r_dmactive  <= 1'b0;
      r_bus_ready <= 1'b0;
      r_dmi_rdata <= '0;
      r_bus_rdata <= '0;
    end else begin
      if (w_dmi_we && dmi_addr == 7'h10) begin
        r_haltreq  <= dmi_wdata[31];
        r_dmactive <= dmi_wdata[0];
      end
      r_bus_ready <= bus_valid & ~r_bus_ready;
      if (w_dmi_re)   r_dmi_rdata <= w_dmi_rval;
      if (w_bus_fire) r_bus_rdata <= w_bus_rval;
    end
  end

  // Bus writes are issued first so a same-cycle DMI write to the same word wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DATA_COUNT; i++)   r_data[i]    <= '0;
      for (int unsigned i = 0; i < PROGBUF_SIZE; i++) r_progbuf[i] <= NOP;
    end else if (!r_dmactive) begin
      for (int unsigned i = 0; i < DATA_COUNT; i++)   r_data[i]    <= '0;
      for (int unsigned i = 0; i < PROGBUF_SIZE; i++) r_progbuf[i] <= NOP;
    end else begin
      for (int unsigned i = 0; i < DATA_COUNT; i++) begin
        if (w_bus_we && bus_addr == 18'(32'h100 + i))         r_data[i] <= bus_wdata;
        if (w_dmi_we && !w_busy && dmi_addr == 7'(32'h04 + i)) r_data[i] <= dmi_wdata;
      end
      for (int unsigned i = 0; i < PROGBUF_SIZE; i++) begin
        if (w_bus_we && bus_addr == 18'(i))                    r_progbuf[i] <= bus_wdata;
        if (w_dmi_we && !w_busy && dmi_addr == 7'(32'h20 + i)) r_progbuf[i] <= dmi_wdata;
      end
    end
  end
endmodule

// File: tb/tb_dm_core.sv
// tb_dm_core: directed scenarios plus randomized DMI/bus traffic checked against a behavioural model.
module tb_dm_core;
  localparam int DC  = 2;
  localparam int PB  = 8;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dmi_valid, dmi_wr;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;
  logic        bus_valid, bus_ready, bus_write;
  logic [17:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        hart_halted, haltreq;

  int n_tests = 0;
  int n_fail  = 0;

  dm_core #(.DATA_COUNT(DC), .PROGBUF_SIZE(PB), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .dmi_valid(dmi_valid), .dmi_wr(dmi_wr), .dmi_addr(dmi_addr),
    .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .hart_halted(hart_halted), .haltreq(haltreq)
  );

  always #5 clk = ~clk;

  // Reference model state; phase 0 = no command, 1 = waiting for hart to fetch GO, 2 = hart executing.
  logic [31:0] m_data [DC];
  logic [31:0] m_pb   [PB];
  logic        m_haltreq, m_dmactive, m_ready, m_fired, m_dmi_rd;
  logic [2:0]  m_cmderr;
  int          m_phase, m_tcnt;
  logic [31:0] m_dmi_rdata, m_bus_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DC; i++) m_data[i] = 32'h0;
    for (int i = 0; i < PB; i++) m_pb[i] = 32'h13;
    m_haltreq = 0; m_dmactive = 0; m_ready = 0; m_fired = 0; m_dmi_rd = 0;
    m_cmderr = 0; m_phase = 0; m_tcnt = 0; m_dmi_rdata = 0; m_bus_rdata = 0;
  endfunction

  function automatic logic [31:0] dmi_val(input int a);
    int busy = (m_phase != 0) ? 1 : 0;
    if (a >= 4 && a < 4 + DC)   return m_data[a - 4];
    if (a >= 32 && a < 32 + PB) return m_pb[a - 32];
    if (a == 16) return m_haltreq * 32'h8000_0000 + 32'(m_dmactive);
    if (a == 17) return (hart_halted ? 32'h300 : 32'h0) + 32'd2;
    if (a == 22) return PB * 32'h0100_0000 + busy * 32'h1000 + m_cmderr * 32'h100 + DC;
    return 32'h0;
  endfunction

  function automatic logic [31:0] bus_val(input int a);
    if (a < PB)                   return m_pb[a];
    if (a == PB)                  return 32'h0010_0073;
    if (a >= 256 && a < 256 + DC) return m_data[a - 256];
    if (a == 512)                 return (m_phase == 1) ? 32'd1 : 32'd0;
    return 32'h0;
  endfunction

  function automatic void model_step();
    bit busy = (m_phase != 0);
    int a = int'(dmi_addr);
    int b = int'(bus_addr);
    int nphase = m_phase;
    logic [2:0] ncerr = m_cmderr;
    m_fired  = bus_valid && m_ready;
    m_dmi_rd = dmi_valid && !dmi_wr;
    if (m_dmi_rd) m_dmi_rdata = dmi_val(a);
    if (m_fired)  m_bus_rdata = bus_val(b);
    m_ready = bus_valid && !m_ready;
    if (!m_dmactive) begin
      for (int i = 0; i < DC; i++) m_data[i] = 0;
      for (int i = 0; i < PB; i++) m_pb[i] = 32'h13;
      nphase = 0; ncerr = 0;
    end else begin
      if (m_fired && bus_write) begin
        if (b < PB) m_pb[b] = bus_wdata;
        else if (b >= 256 && b < 256 + DC) m_data[b - 256] = bus_wdata;
      end
      if (dmi_valid && dmi_wr) begin
        if (a >= 4 && a < 4 + DC) begin
          if (busy) ncerr = 1; else m_data[a - 4] = dmi_wdata;
        end else if (a >= 32 && a < 32 + PB) begin
          if (busy) ncerr = 1; else m_pb[a - 32] = dmi_wdata;
        end else if (a == 22) ncerr = m_cmderr & ~dmi_wdata[10:8];
        else if (a == 23) begin
          if (busy) ncerr = 1;
          else if (m_cmderr == 0) begin
            if (!hart_halted) ncerr = 4; else nphase = 1;
          end
        end
      end
      if (m_fired && m_phase == 1 && !bus_write && b == 512) nphase = 2;
      if (m_fired && m_phase == 2 && bus_write && b == 513) nphase = 0;
      if (m_fired && m_phase == 2 && bus_write && b == 514) begin nphase = 0; ncerr = 3; end
`ifdef DM_TIMEOUT_EN
      if (busy) begin
        m_tcnt++;
        if (m_tcnt >= TMO) begin nphase = 0; ncerr = 3; end
      end
`endif
    end
    if (dmi_valid && dmi_wr && a == 16) begin
      m_haltreq  = dmi_wdata[31];
      m_dmactive = dmi_wdata[0];
    end
    m_phase = nphase; m_cmderr = ncerr;
    if (m_phase == 0) m_tcnt = 0;
  endfunction

  task automatic cyc();
    if (!resetn) model_reset(); else model_step();
    @(posedge clk); #1;
    chk("bus_ready", bus_ready, m_ready);
    chk("haltreq", haltreq, m_haltreq & m_dmactive);
    if (m_dmi_rd) chk("dmi_rdata", dmi_rdata, m_dmi_rdata);
    if (m_fired)  chk("bus_rdata", bus_rdata, m_bus_rdata);
  endtask

  task automatic dmi_w(input logic [6:0] a, input logic [31:0] d);
    dmi_valid = 1; dmi_wr = 1; dmi_addr = a; dmi_wdata = d;
    cyc();
    dmi_valid = 0; dmi_wr = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
    dmi_valid = 1; dmi_wr = 0; dmi_addr = a;
    cyc();
    dmi_valid = 0;
    chk(tag, dmi_rdata, exp);
  endtask

  task automatic bus_acc(input logic wr, input logic [17:0] a, input logic [31:0] d);
    bus_valid = 1; bus_write = wr; bus_addr = a; bus_wdata = d;
    cyc();
    cyc();
    bus_valid = 0; bus_write = 0;
  endtask

  task automatic finish_cmd(input logic [17:0] end_addr);
    bus_acc(0, 18'h200, 0);
    bus_acc(1, end_addr, 0);
  endtask

  logic [6:0]  dmi_alist [11] = '{7'h04, 7'h05, 7'h06, 7'h10, 7'h11, 7'h16, 7'h17, 7'h20, 7'h27, 7'h28, 7'h3f};
  logic [17:0] bus_alist [14] = '{18'd0, 18'd1, 18'd2, 18'd3, 18'd7, 18'd8, 18'h100, 18'h101,
                                  18'h102, 18'h200, 18'h201, 18'h202, 18'h203, 18'h300};

  initial begin
    resetn = 0; dmi_valid = 0; dmi_wr = 0; dmi_addr = 0; dmi_wdata = 0;
    bus_valid = 0; bus_write = 0; bus_addr = 0; bus_wdata = 0; hart_halted = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmi_rdata", dmi_rdata, 0);
    chk("rst_bus_rdata", bus_rdata, 0);
    chk("rst_bus_ready", bus_ready, 0);
    chk("rst_haltreq", haltreq, 0);
    resetn = 1;

    dmi_w(7'h10, 32'h1);
    dmi_w(7'h04, 32'h1234_5678);
    rd_chk("data0_rw", 7'h04, 32'h1234_5678);
    rd_chk("abscs_default", 7'h16, 32'h0800_0002);
    rd_chk("progbuf_nop", 7'h20, 32'h13);

    hart_halted = 1;
    dmi_w(7'h17, 32'h0);
    rd_chk("abscs_busy", 7'h16, 32'h0800_1002);
    bus_acc(0, 18'h200, 0);
    chk("go_flag", bus_rdata, 1);
    rd_chk("abscs_exec", 7'h16, 32'h0800_1002);
    bus_acc(1, 18'h201, 0);
    rd_chk("abscs_done", 7'h16, 32'h0800_0002);

    dmi_w(7'h17, 32'h0);
    dmi_w(7'h17, 32'h0);
    rd_chk("abscs_busyerr", 7'h16, 32'h0800_1102);
    finish_cmd(18'h201);
    rd_chk("abscs_err1_kept", 7'h16, 32'h0800_0102);
    dmi_w(7'h16, 32'h700);
    rd_chk("abscs_w1c", 7'h16, 32'h0800_0002);

    hart_halted = 0;
    dmi_w(7'h10, 32'h8000_0001);
    chk("haltreq_set", haltreq, 1);
    dmi_w(7'h17, 32'h0);
    rd_chk("abscs_nothalted", 7'h16, 32'h0800_0402);
    dmi_w(7'h10, 32'h1);
    chk("haltreq_clr", haltreq, 0);
    dmi_w(7'h16, 32'h700);

    hart_halted = 1;
    dmi_w(7'h17, 32'h0);
    finish_cmd(18'h202);
    rd_chk("abscs_except", 7'h16, 32'h0800_0302);
    dmi_w(7'h16, 32'h700);

    bus_acc(0, 18'd8, 0);
    chk("ebreak", bus_rdata, 32'h0010_0073);
    bus_acc(1, 18'd3, 32'hcafe_f00d);
    rd_chk("progbuf_bus_wr", 7'h23, 32'hcafe_f00d);
    bus_valid = 1; bus_write = 1; bus_addr = 18'h100; bus_wdata = 32'haaaa_aaaa;
    cyc();
    dmi_valid = 1; dmi_wr = 1; dmi_addr = 7'h04; dmi_wdata = 32'h5555_5555;
    cyc();
    dmi_valid = 0; dmi_wr = 0; bus_valid = 0; bus_write = 0;
    rd_chk("dmi_priority", 7'h04, 32'h5555_5555);
    dmi_w(7'h17, 32'h0);
    dmi_w(7'h20, 32'hdead_beef);
    rd_chk("buf_wr_busy_err", 7'h16, 32'h0800_1102);
    rd_chk("buf_wr_dropped", 7'h20, 32'h13);
    finish_cmd(18'h201);
    dmi_w(7'h16, 32'h700);

    dmi_w(7'h17, 32'h0);
`ifdef DM_TIMEOUT_EN
    for (int i = 0; i < TMO + 4; i++) rd_chk("tmo_progress", 7'h16, m_phase != 0 ? 32'h0800_1002 : 32'h0800_0302);
    rd_chk("abscs_timeout", 7'h16, 32'h0800_0302);
    dmi_w(7'h16, 32'h700);
`else
    repeat (40) cyc();
    rd_chk("abscs_no_timeout", 7'h16, 32'h0800_1002);
    finish_cmd(18'h201);
`endif

    dmi_w(7'h17, 32'h0);
    bus_acc(0, 18'h200, 0);
    chk("go_flag_pre_rst", bus_rdata, 1);
    resetn = 0;
    #2;
    chk("arst_bus_rdata", bus_rdata, 0);
    chk("arst_dmi_rdata", dmi_rdata, 0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
    dmi_w(7'h10, 32'h1);
    rd_chk("abscs_after_rst", 7'h16, 32'h0800_0002);
    rd_chk("data_after_rst", 7'h04, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      dmi_valid = ($urandom_range(0, 2) == 0);
      dmi_wr    = 1'($urandom_range(0, 1));
      dmi_addr  = dmi_alist[$urandom_range(0, 10)];
      dmi_wdata = $urandom;
      if (dmi_addr == 7'h10)
        dmi_wdata = {1'($urandom_range(0, 1)), 30'b0, 1'($urandom_range(0, 7) != 0)};
      if (m_fired || !bus_valid) begin
        bus_valid = 1'($urandom_range(0, 1));
        bus_write = 1'($urandom_range(0, 1));
        bus_addr  = bus_alist[$urandom_range(0, 13)];
        bus_wdata = $urandom;
        if (m_phase == 1 && $urandom_range(0, 1) == 1) begin
          bus_write = 0; bus_addr = 18'h200;
        end
        if (m_phase == 2 && $urandom_range(0, 1) == 1) begin
          bus_write = 1; bus_addr = ($urandom_range(0, 3) == 0) ? 18'h202 : 18'h201;
        end
      end
      if ($urandom_range(0, 40) == 0) hart_halted = ~hart_halted;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_core.md
DM_CORE -- requirements
Module: dm_core

Interface
REQ-001 SHALL have parameter DATA_COUNT, default 2, number of abstract data registers (1..12).
REQ-002 SHALL have parameter PROGBUF_SIZE, default 8, number of program buffer words (1..16).
REQ-003 SHALL have parameter TIMEOUT, default 1024, command timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port dmi_valid  input  1  DMI access strobe, one cycle per access.
REQ-007 SHALL have port dmi_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port dmi_addr  input  7  DMI register address.
REQ-009 SHALL have port dmi_wdata  input  32  DMI write data.
REQ-010 SHALL have port dmi_rdata  output  32  DMI read data, registered.
REQ-011 SHALL have port bus_valid  input  1  hart-side bus request.
REQ-012 SHALL have port bus_ready  output  1  hart-side bus acknowledge.
REQ-013 SHALL have port bus_write  input  1  1 = bus write.
REQ-014 SHALL have port bus_addr  input  18 ([19:2])  bus word address.
REQ-015 SHALL have port bus_wdata  input  32  bus write data.
REQ-016 SHALL have port bus_rdata  output  32  bus read data, registered.
REQ-017 SHALL have port hart_halted  input  1  hart reports halted.
REQ-018 SHALL have port haltreq  output  1  halt request to hart.

Function
REQ-019 SHALL decode DMI: 0x04+i data[i] (i<DATA_COUNT); 0x10 dmcontrol (bit31 haltreq, bit0 dmactive); 0x11 dmstatus (read-only, bits 9/8 allhalted/anyhalted = hart_halted, bits 3:0 = 2); 0x16 abstractcs; 0x17 command (write-only); 0x20+i progbuf[i] (i<PROGBUF_SIZE); others read 0, writes ignored.
REQ-020 SHALL update dmi_rdata one cycle after a DMI read; dmi_rdata holds otherwise.
REQ-021 SHALL drive haltreq = dmcontrol.haltreq AND dmactive.
REQ-022 SHALL, while dmactive=0, hold data, progbuf, abstractcs and FSM at reset values and ignore DMI writes except to dmcontrol.
REQ-023 SHALL implement abstractcs: bits 28:24 progbufsize = PROGBUF_SIZE, bit 12 busy, bits 10:8 cmderr, bits 3:0 datacount = DATA_COUNT; writing 1s to cmderr clears those bits (W1C).
REQ-024 SHALL run FSM IDLE -> GO on a command write when busy=0 and cmderr=0; GO -> EXEC on bus read of GO flag; EXEC -> IDLE on bus write to DONE or EXCEPT; busy=1 in GO and EXEC.
REQ-025 SHALL, on command write while busy=1, set cmderr=1 and leave FSM unchanged; while cmderr!=0 and busy=0, ignore command writes.
REQ-026 SHALL, on command write with hart_halted=0, set cmderr=4 and remain IDLE.
REQ-027 SHALL set cmderr=3 on bus write to EXCEPT; DONE leaves cmderr unchanged.
REQ-028 SHALL map bus word addresses: 0..PROGBUF_SIZE-1 progbuf; PROGBUF_SIZE returns 0x00100073 (ebreak), read-only; 0x100+i data[i]; 0x200 GO flag (reads 1 in GO, else 0); 0x201 DONE (write); 0x202 EXCEPT (write); unmapped reads 0.
REQ-029 SHALL assert bus_ready the cycle after bus_valid, deassert it the cycle after bus_valid && bus_ready; a write takes effect and bus_rdata loads on the bus_valid && bus_ready cycle.
REQ-030 SHALL give DMI writes priority over simultaneous bus writes to the same data/progbuf word.
REQ-031 SHALL reject DMI writes to data/progbuf while busy=1 (write dropped, cmderr=1).

Reset
REQ-032 SHALL, on resetn low, asynchronously clear dmi_rdata, bus_rdata, bus_ready, dmcontrol, abstractcs.cmderr, FSM to IDLE, data and timeout counter; progbuf words reset to 0x00000013 (nop).
REQ-033 SHALL, on reset mid-command, abort to IDLE with busy=0, cmderr=0.

Configuration
REQ-034 SHALL, with DM_TIMEOUT_EN defined, count clk cycles in GO/EXEC and on reaching TIMEOUT go to IDLE with cmderr=3; counter clears on entering GO.
REQ-035 SHALL, without DM_TIMEOUT_EN, have no counter and wait in GO/EXEC indefinitely.

Verification
REQ-036 SHALL cover: DMI write 0x12345678 to 0x04, read 0x04 -> dmi_rdata 0x12345678 next cycle; read 0x16 with defaults -> 0x08000002.
REQ-037 SHALL cover: dmactive=1, hart_halted=1, write command; bus read 0x200 -> 1, bus write 0x201 -> busy 1 then 0, cmderr 0.
REQ-038 SHALL cover: second command write during busy -> cmderr=1; DMI write 0x700 to 0x16 -> cmderr=0.
REQ-039 SHALL cover: command with hart_halted=0 -> cmderr=4, busy stays 0, haltreq follows dmcontrol bit31.
REQ-040 SHALL cover: DM_TIMEOUT_EN, TIMEOUT=16, command issued, no bus access -> busy clears after 16 cycles, cmderr=3; resetn pulse mid-command -> busy=0, cmderr=0, bus_rdata=0.
